// File: rtl/axi_pattern_master.sv
// axi_pattern_master
//
// AXI4 initiator that writes one INCR burst of a deterministic pattern, collects the write
// response, reads the same range back and counts mismatching beats. error_count saturates
// at 16'hFFFF and is cleared when a new run starts.
//
// Build option:
//   AXI_PATMST_LFSR_EN  pattern is a Galois LFSR sequence (x^32+x^22+x^2+x+1) seeded by
//                       `seed` (zero seed replaced by 1). Undefined: pattern is seed+k.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, sampled only while idle
//   base_addr         burst start address (forced to beat alignment)
//   burst_len         AXLEN of both bursts (burst_len+1 beats)
//   seed              pattern seed
//   busy              high whenever not idle
//   done              one-cycle pulse after the last read beat
//   error_count       error count of the last run
//   m_axi_aw*/w*/b*   AXI write address, data and response channels
//   m_axi_ar*/r*      AXI read address and data channels
// All outputs are driven from flops or constants.

module axi_pattern_master #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            burst_len,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           error_count,

  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ID_WIDTH-1:0]   TxnId    = ID_WIDTH'(TXN_ID);
  localparam logic [2:0]            AxSize   = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StWresp,
    StRaddr,
    StRdata
  } state_e;

  // First pattern word of a run.
  function automatic logic [31:0] pat_init(input logic [31:0] s);
`ifdef AXI_PATMST_LFSR_EN
    pat_init = (s == 32'h0) ? 32'h1 : s;
`else
    pat_init = s;
`endif
  endfunction

  // Pattern word of beat k+1 from that of beat k.
  function automatic logic [31:0] pat_next(input logic [31:0] p);
`ifdef AXI_PATMST_LFSR_EN
    pat_next = p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
    pat_next = p + 32'h1;
`endif
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat_rep(input logic [31:0] p);
    pat_rep = {(DATA_WIDTH / 32){p}};
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [31:0]             p0_q, p0_d;
  logic [31:0]             pat_q, pat_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wlast_q, wlast_d;
  logic [7:0]              beat_q, beat_d;
  logic [15:0]             err_q, err_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    err_inc;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_beat, r_bad, b_bad;

  assign aw_hs       = awvalid_q & m_axi_awready;
  assign w_hs        = wvalid_q & m_axi_wready;
  assign b_hs        = bready_q & m_axi_bvalid;
  assign ar_hs       = arvalid_q & m_axi_arready;
  assign r_hs        = rready_q & m_axi_rvalid;
  assign r_last_beat = (beat_q == len_q);

  assign b_bad = (m_axi_bresp != 2'b00) || (m_axi_bid != TxnId);
  assign r_bad = (m_axi_rdata != pat_rep(pat_q)) || (m_axi_rresp != 2'b00) ||
                 (m_axi_rid != TxnId) || (m_axi_rlast != r_last_beat);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)                state_d = StWaddr;
      StWaddr: if (aw_hs)                state_d = StWdata;
      StWdata: if (w_hs && wlast_q)      state_d = StWresp;
      StWresp: if (b_hs)                 state_d = StRaddr;
      StRaddr: if (ar_hs)                state_d = StRdata;
      StRdata: if (r_hs && r_last_beat)  state_d = StIdle;
      default:                           state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    p0_d    = p0_q;
    pat_d   = pat_q;
    wdata_d = wdata_q;
    wlast_d = wlast_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    err_inc = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr & AddrMask;
          len_d   = burst_len;
          p0_d    = pat_init(seed);
          pat_d   = pat_init(seed);
          wdata_d = pat_rep(pat_init(seed));
          wlast_d = (burst_len == 8'd0);
          beat_d  = 8'd0;
          err_d   = 16'd0;
        end
      end
      StWdata: begin
        if (w_hs) begin
          // Payload for the next beat is loaded the cycle after acceptance.
          beat_d  = beat_q + 8'd1;
          pat_d   = pat_next(pat_q);
          wdata_d = pat_rep(pat_next(pat_q));
          wlast_d = ((beat_q + 8'd1) == len_q);
        end
      end
      StWresp: begin
        if (b_hs) begin
          err_inc = b_bad;
          beat_d  = 8'd0;
          pat_d   = p0_q;  // replay the sequence for the read-back compare
        end
      end
      StRdata: begin
        if (r_hs) begin
          err_inc = r_bad;
          beat_d  = beat_q + 8'd1;
          pat_d   = pat_next(pat_q);
          done_d  = r_last_beat;
        end
      end
      default: ;
    endcase

    if (err_inc && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    // Handshake outputs registered from the upcoming state.
    busy_d    = (state_d != StIdle);
    awvalid_d = (state_d == StWaddr);
    wvalid_d  = (state_d == StWdata);
    bready_d  = (state_d == StWresp);
    arvalid_d = (state_d == StRaddr);
    rready_d  = (state_d == StRdata);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      p0_q      <= '0;
      pat_q     <= '0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
      beat_q    <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      p0_q      <= p0_d;
      pat_q     <= pat_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error_count = err_q;

  assign m_axi_awid    = TxnId;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AxSize;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = wlast_q;
  assign m_axi_wvalid = wvalid_q;

  assign m_axi_bready = bready_q;

  assign m_axi_arid    = TxnId;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AxSize;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready = rready_q;

endmodule

// File: tb/tb_axi_pattern_master.sv
// Directed bench for axi_pattern_master with a behavioural AXI RAM responder that can stall
// every channel and inject response faults.

module tb_axi_pattern_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [31:0] seed = '0;
  logic        busy, done;
  logic [15:0] error_count;

  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int errors = 0;
  int checks = 0;

  // Responder controls.
  bit          stall_en = 1'b0;
  logic [1:0]  inj_bresp = 2'b00;
  int          inj_rdata_beat = -1;
  int          inj_rresp_beat = -1;
  bit          inj_early_rlast = 1'b0;

  // Responder state.
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait, r_next_wait;
  int          wbeat, rbeat;
  bit          b_pend, r_active;
  logic [31:0] aw_addr_c, ar_addr_c;
  logic [7:0]  aw_len_c, ar_len_c;
  logic [2:0]  aw_size_c;
  logic [1:0]  aw_burst_c;
  logic [7:0]  aw_strb_c;
  logic [63:0] mem [0:1023];
  logic [63:0] w_log [0:255];
  logic        wlast_log [0:255];
  bit          aw_hold, w_hold, ar_hold;
  logic [39:0] aw_prev, ar_prev;
  logic [64:0] w_prev;
  int          stab_err = 0;

  assign awready = (aw_wait == 0);
  assign wready  = (w_wait == 0);
  assign arready = (ar_wait == 0);
  assign bid     = 4'd0;
  assign rid     = 4'd0;

  axi_pattern_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .burst_len     (burst_len),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .error_count   (error_count),
    .m_axi_awid    (awid),
    .m_axi_awaddr  (awaddr),
    .m_axi_awlen   (awlen),
    .m_axi_awsize  (awsize),
    .m_axi_awburst (awburst),
    .m_axi_awlock  (awlock),
    .m_axi_awcache (awcache),
    .m_axi_awprot  (awprot),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wlast   (wlast),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bid     (bid),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_arid    (arid),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arlock  (arlock),
    .m_axi_arcache (arcache),
    .m_axi_arprot  (arprot),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rid     (rid),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat_word(input logic [31:0] s, input int k);
    logic [31:0] p;
`ifdef AXI_PATMST_LFSR_EN
    p = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < k; i++) p = p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
    p = s + 32'(k);
`endif
    return p;
  endfunction

  function automatic logic [63:0] r_data_for(input int b);
    int idx;
    idx = (int'(ar_addr_c >> 3) + b) % 1024;
    return mem[idx] ^ ((b == inj_rdata_beat) ? 64'h1 : 64'h0);
  endfunction

  function automatic int draw_wait();
    return stall_en ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Behavioural AXI RAM: one-cycle B and R latency, optional random stalls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0; r_next_wait <= 0;
      wbeat <= 0; rbeat <= 0; b_pend <= 0; r_active <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rdata <= 0; rresp <= 0; rlast <= 0;
      aw_hold <= 0; w_hold <= 0; ar_hold <= 0;
    end else begin
      r_next_wait <= draw_wait();
      if (!awvalid || awready) aw_wait <= draw_wait(); else if (aw_wait != 0) aw_wait <= aw_wait - 1;
      if (!wvalid || wready)   w_wait  <= draw_wait(); else if (w_wait != 0)  w_wait  <= w_wait - 1;
      if (!arvalid || arready) ar_wait <= draw_wait(); else if (ar_wait != 0) ar_wait <= ar_wait - 1;

      if (awvalid && awready) begin
        aw_addr_c <= awaddr; aw_len_c <= awlen; aw_size_c <= awsize; aw_burst_c <= awburst;
        wbeat <= 0;
      end
      if (wvalid && wready) begin
        mem[(int'(aw_addr_c >> 3) + wbeat) % 1024] <= wdata;
        w_log[wbeat % 256]     <= wdata;
        wlast_log[wbeat % 256] <= wlast;
        aw_strb_c <= wstrb;
        wbeat <= wbeat + 1;
        if (wlast) begin
          b_pend <= 1;
          b_wait <= draw_wait();
        end
      end
      if (bvalid && bready) begin
        bvalid <= 0;
      end else if (b_pend) begin
        if (b_wait == 0) begin
          bvalid <= 1; bresp <= inj_bresp; b_pend <= 0;
        end else begin
          b_wait <= b_wait - 1;
        end
      end

      if (arvalid && arready) begin
        ar_addr_c <= araddr; ar_len_c <= arlen;
        r_active <= 1; rbeat <= 0; r_wait <= draw_wait();
      end
      if (rvalid && rready) begin
        if (rbeat == int'(ar_len_c)) begin
          rvalid <= 0; r_active <= 0;
        end else begin
          rbeat  <= rbeat + 1;
          r_wait <= r_next_wait;
          if (r_next_wait == 0) begin
            rdata <= r_data_for(rbeat + 1);
            rresp <= ((rbeat + 1) == inj_rresp_beat) ? 2'b10 : 2'b00;
            rlast <= ((rbeat + 1) == int'(ar_len_c));
          end else begin
            rvalid <= 0;
          end
        end
      end else if (r_active && !rvalid) begin
        if (r_wait == 0) begin
          rvalid <= 1;
          rdata  <= r_data_for(rbeat);
          rresp  <= (rbeat == inj_rresp_beat) ? 2'b10 : 2'b00;
          rlast  <= (rbeat == int'(ar_len_c)) || (inj_early_rlast && rbeat == 0);
        end else begin
          r_wait <= r_wait - 1;
        end
      end

      // A stalled VALID must stay up with an unchanged payload.
      aw_hold <= awvalid && !awready;
      w_hold  <= wvalid && !wready;
      ar_hold <= arvalid && !arready;
      aw_prev <= {awaddr, awlen};
      w_prev  <= {wdata, wlast};
      ar_prev <= {araddr, arlen};
      if ((aw_hold && (!awvalid || {awaddr, awlen} !== aw_prev)) ||
          (w_hold && (!wvalid || {wdata, wlast} !== w_prev)) ||
          (ar_hold && (!arvalid || {araddr, arlen} !== ar_prev))) begin
        stab_err <= stab_err + 1;
      end
    end
  end

  // Starts a run and waits (bounded) for done; cycles counts clock edges from start to done.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] sd,
                         output int cycles);
    bit seen;
    seen = 0;
    cycles = 0;
    @(negedge clk);
    base_addr = addr; burst_len = len; seed = sd; start = 1'b1;
    while (!seen && cycles < 4000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL run_timeout: done=%b after %0d cycles, required done=1", done, cycles);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [7:0] got;
    got = {awvalid, wvalid, bready, arvalid, rready, busy, done, |error_count};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL %s: aw/w/b/ar/r/busy/done/err=%b required 00000000", tag, got);
    end
    checks++;
    if ({awaddr, wdata} !== 96'h0) begin
      errors++;
      $display("FAIL %s_payload: awaddr=%h wdata=%h required 0", tag, awaddr, wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    run_txn(32'h100, 8'd3, 32'h10, cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL basic_latency: %0d cycles required 14", cyc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: busy=%b required 0", busy); end
    checks++;
    if (error_count !== 16'd0) begin
      errors++; $display("FAIL basic_errcnt: %0d required 0", error_count);
    end
    for (int k = 0; k < 4; k++) begin
      logic [63:0] exp;
      exp = {2{pat_word(32'h10, k)}};
`ifndef AXI_PATMST_LFSR_EN
      exp = {2{32'h10 + 32'(k)}};
`endif
      checks++;
      if (w_log[k] !== exp) begin
        errors++; $display("FAIL basic_wdata%0d: %h required %h", k, w_log[k], exp);
      end
      checks++;
      if (wlast_log[k] !== (k == 3)) begin
        errors++; $display("FAIL basic_wlast%0d: %b required %b", k, wlast_log[k], k == 3);
      end
    end
    checks++;
    if ({aw_addr_c, aw_len_c, aw_size_c, aw_burst_c, aw_strb_c} !== {32'h100, 8'd3, 3'd3, 2'b01, 8'hFF})
    begin
      errors++;
      $display("FAIL basic_aw: addr=%h len=%0d size=%0d burst=%b strb=%h required 100/3/3/01/ff",
               aw_addr_c, aw_len_c, aw_size_c, aw_burst_c, aw_strb_c);
    end
    checks++;
    if ({ar_addr_c, ar_len_c, arsize, arburst} !== {32'h100, 8'd3, 3'd3, 2'b01}) begin
      errors++;
      $display("FAIL basic_ar: addr=%h len=%0d size=%0d burst=%b required 100/3/3/01",
               ar_addr_c, ar_len_c, arsize, arburst);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done=%b required 0", done); end
  endtask

  task automatic test_stall();
    int cyc, bad_w, bad_last;
    stall_en = 1'b1;
    run_txn(32'h203, 8'd255, 32'hA5A5_0000, cyc);
    stall_en = 1'b0;
    bad_w = 0; bad_last = 0;
    for (int k = 0; k < 256; k++) begin
      if (w_log[k] !== {2{pat_word(32'hA5A5_0000, k)}}) bad_w++;
      if (wlast_log[k] !== (k == 255)) bad_last++;
    end
    checks++;
    if (error_count !== 16'd0) begin
      errors++; $display("FAIL stall_errcnt: %0d required 0", error_count);
    end
    checks++;
    if (stab_err !== 0) begin
      errors++; $display("FAIL stall_stability: %0d unstable cycles required 0", stab_err);
    end
    checks++;
    if (bad_w !== 0 || bad_last !== 0) begin
      errors++; $display("FAIL stall_wbeats: %0d data / %0d wlast wrong required 0", bad_w, bad_last);
    end
    checks++;
    if (aw_addr_c !== 32'h200) begin
      errors++; $display("FAIL stall_align: awaddr=%h required 00000200", aw_addr_c);
    end
  endtask

  task automatic test_rcorrupt();
    int cyc;
    inj_rdata_beat = 2; inj_rresp_beat = 5;
    run_txn(32'h400, 8'd7, 32'h1234_5678, cyc);
    inj_rdata_beat = -1; inj_rresp_beat = -1;
    checks++;
    if (error_count !== 16'd2) begin
      errors++; $display("FAIL rcorrupt_errcnt: %0d required 2", error_count);
    end
  endtask

  task automatic test_bresp_rlast();
    int cyc;
    inj_bresp = 2'b10; inj_early_rlast = 1'b1;
    run_txn(32'h500, 8'd1, 32'hFFFF_FFFE, cyc);
    inj_bresp = 2'b00; inj_early_rlast = 1'b0;
    checks++;
    if (error_count !== 16'd2) begin
      errors++; $display("FAIL bresp_rlast_errcnt: %0d required 2", error_count);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    @(negedge clk);
    base_addr = 32'h600; burst_len = 8'd15; seed = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (wbeat < 2 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (wbeat < 2) begin errors++; $display("FAIL midrst_wait: wbeat=%0d required >=2", wbeat); end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    @(negedge clk);
    check_idle_outputs("midrst_held");
    rst_n = 1'b1;
    run_txn(32'h300, 8'd3, 32'h77, cyc);
    checks++;
    if (error_count !== 16'd0 || cyc !== 14) begin
      errors++; $display("FAIL midrst_rerun: errcnt=%0d cycles=%0d required 0/14", error_count, cyc);
    end
  endtask

  task automatic test_seed_zero();
    int cyc;
    logic [63:0] e0, e1;
`ifdef AXI_PATMST_LFSR_EN
    e0 = {2{32'h0000_0001}};
    e1 = {2{32'h8020_0003}};
`else
    e0 = {2{32'h0000_0000}};
    e1 = {2{32'h0000_0001}};
`endif
    run_txn(32'h700, 8'd1, 32'h0, cyc);
    checks++;
    if (w_log[0] !== e0) begin errors++; $display("FAIL seed0_beat0: %h required %h", w_log[0], e0); end
    checks++;
    if (w_log[1] !== e1) begin errors++; $display("FAIL seed0_beat1: %h required %h", w_log[1], e1); end
    checks++;
    if (error_count !== 16'd0) begin
      errors++; $display("FAIL seed0_errcnt: %0d required 0", error_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_rcorrupt();
    test_bresp_rlast();
    test_reset_mid();
    test_seed_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
